// File: rtl/uart_rx.sv
// Oversampling UART receiver (8N1/8E1/8O1) driven by a per-sample strobe from the baud generator.
// Emits each received byte with frame/parity error flags as a one-cycle valid pulse.
module uart_rx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pls_rx,
  input  logic [4:0]        osm_rate,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              rxd,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              parity_err,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [3:0] BIT_LAST = 4'(DATA_W - 1);

  state_t            state, state_nx;
  logic              rx_meta, rxs, rxs_d;
  logic [4:0]        tick_cnt;
  logic [3:0]        bit_cnt;
  logic [DATA_W-1:0] shift;
  logic [4:0]        osm_l;
  logic              pen_l, podd_l, par_bad;
  logic [4:0]        half;
  logic              start_det, half_hit, tick_last;

  always_comb begin
    half      = osm_l >> 1;
    start_det = rxs_d & ~rxs;
    half_hit  = pls_rx && ((tick_cnt + 5'd1) == half);
    tick_last = pls_rx && ((tick_cnt + 5'd1) == osm_l);
    busy      = (state != IDLE);
    state_nx  = state;
    case (state)
      IDLE:    if (start_det) state_nx = START;
      // A line already back high at the start midpoint is treated as a glitch.
      START:   if (half_hit) state_nx = rxs ? IDLE : DATA;
      DATA:    if (tick_last && (bit_cnt == BIT_LAST)) state_nx = pen_l ? PARITY : STOP;
      PARITY:  if (tick_last) state_nx = STOP;
      STOP:    if (tick_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rx_meta    <= 1'b1;
      rxs        <= 1'b1;
      rxs_d      <= 1'b1;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      osm_l      <= '0;
      pen_l      <= 1'b0;
      podd_l     <= 1'b0;
      par_bad    <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_meta  <= rxd;
      rxs      <= rx_meta;
      rxs_d    <= rxs;
      state    <= state_nx;
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start_det) begin
            osm_l    <= osm_rate;
            pen_l    <= parity_en;
            podd_l   <= parity_odd;
            tick_cnt <= '0;
            bit_cnt  <= '0;
          end
        end
        START: begin
          if (pls_rx) tick_cnt <= half_hit ? 5'd0 : tick_cnt + 5'd1;
        end
        DATA: begin
          if (pls_rx) begin
            if (tick_last) begin
              shift    <= {rxs, shift[DATA_W-1:1]};
              tick_cnt <= '0;
              bit_cnt  <= bit_cnt + 4'd1;
            end else begin
              tick_cnt <= tick_cnt + 5'd1;
            end
          end
        end
        PARITY: begin
          if (pls_rx) begin
            if (tick_last) begin
              par_bad  <= ((^shift) ^ rxs) != podd_l;
              tick_cnt <= '0;
            end else begin
              tick_cnt <= tick_cnt + 5'd1;
            end
          end
        end
        STOP: begin
          if (pls_rx) begin
            if (tick_last) begin
              rx_data    <= shift;
              frame_err  <= ~rxs;
              parity_err <= pen_l & par_bad;
              rx_valid   <= 1'b1;
              tick_cnt   <= '0;
            end else begin
              tick_cnt <= tick_cnt + 5'd1;
            end
          end
        end
        default: tick_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized bench for uart_rx; expected frames come from a queue-based
// model that derives data/flags from what was put on the line.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       pls_rx = 1'b0;
  logic [4:0] osm_rate;
  logic       parity_en, parity_odd, rxd;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, busy;

  uart_rx #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .pls_rx(pls_rx), .osm_rate(osm_rate),
    .parity_en(parity_en), .parity_odd(parity_odd), .rxd(rxd),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Oversample strobe: one pulse every 4 clocks.
  int unsigned pdiv = 0;
  always @(posedge clk) begin
    pdiv   <= (pdiv == 3) ? 0 : pdiv + 1;
    pls_rx <= (pdiv == 3);
  end

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } frm_t;

  frm_t       exp_q[$];
  frm_t       last_e;
  logic [9:0] got_q[$];
  int         checks = 0;
  int         errors = 0;
  int         vhigh = 0;
  int         vpulse = 0;
  logic       rv_prev = 1'b0;
  logic       busy_seen = 1'b0;

  always @(negedge clk) begin
    if (rx_valid) begin
      got_q.push_back({frame_err, parity_err, rx_data});
      vhigh++;
      if (!rv_prev) vpulse++;
    end
    rv_prev = rx_valid;
    if (busy) busy_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int bclk);
    rxd = b;
    wait_clks(bclk);
  endtask

  // Drives one frame and records what the receiver must report for it.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic podd,
                            input int osm, input logic pb, input logic sb, input logic scr);
    frm_t e;
    int   bclk;
    int   ones;
    bclk = osm * 4;
    ones = $countones(d) + (pen ? int'(pb) : 0);
    e.d  = d;
    e.fe = ~sb;
    e.pe = pen && ((ones % 2) != (podd ? 1 : 0));
    exp_q.push_back(e);
    osm_rate   = 5'(osm);
    parity_en  = pen;
    parity_odd = podd;
    send_bit(1'b0, bclk);
    if (scr) begin
      osm_rate   = 5'($urandom_range(4, 16));
      parity_en  = 1'($urandom);
      parity_odd = 1'($urandom);
    end
    for (int i = 0; i < 8; i++) send_bit(d[i], bclk);
    if (pen) send_bit(pb, bclk);
    send_bit(sb, bclk);
  endtask

  task automatic check_frames(input string tag);
    logic [9:0] g;
    frm_t       e;
    chk({tag, " count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, " data"}, g[7:0], e.d);
      chk({tag, " frame_err"}, g[9], e.fe);
      chk({tag, " parity_err"}, g[8], e.pe);
      last_e = e;
    end
    got_q.delete();
    exp_q.delete();
    chk({tag, " held data"}, rx_data, last_e.d);
    chk({tag, " held fe"}, frame_err, last_e.fe);
    chk({tag, " held pe"}, parity_err, last_e.pe);
    chk({tag, " busy idle"}, busy, 1'b0);
  endtask

  initial begin
    logic [7:0] d;
    int         osm;
    logic       pen, podd, pb, sb;

    rst = 1'b1; rxd = 1'b1; osm_rate = 5'd16; parity_en = 1'b0; parity_odd = 1'b0;
    wait_clks(2);
    rst = 1'b0;
    wait_clks(1);
    chk("reset rx_data", rx_data, 8'h00);
    chk("reset rx_valid", rx_valid, 1'b0);
    chk("reset frame_err", frame_err, 1'b0);
    chk("reset parity_err", parity_err, 1'b0);
    chk("reset busy", busy, 1'b0);
    wait_clks(20);

    send_frame(8'hA5, 1'b0, 1'b0, 16, 1'b0, 1'b1, 1'b0);
    send_bit(1'b1, 64);
    check_frames("basic A5");

    send_frame(8'h5A, 1'b1, 1'b0, 16, 1'b1, 1'b1, 1'b0);
    send_bit(1'b1, 64);
    check_frames("even pb1");
    send_frame(8'h5A, 1'b1, 1'b0, 16, 1'b0, 1'b1, 1'b0);
    send_bit(1'b1, 64);
    check_frames("even pb0");
    send_frame(8'h5A, 1'b1, 1'b1, 16, 1'b1, 1'b1, 1'b0);
    send_bit(1'b1, 64);
    check_frames("odd pb1");

    // Bad stop bit followed by a long break: only one frame may be reported.
    send_frame(8'h3C, 1'b0, 1'b0, 16, 1'b0, 1'b0, 1'b0);
    wait_clks(30 * 64);
    check_frames("break");
    send_bit(1'b1, 64);
    send_frame(8'h11, 1'b0, 1'b0, 16, 1'b0, 1'b1, 1'b0);
    send_bit(1'b1, 64);
    check_frames("after break");

    busy_seen = 1'b0;
    rxd = 1'b0;
    wait_clks(20);
    rxd = 1'b1;
    wait_clks(128);
    chk("glitch busy pulse", busy_seen, 1'b1);
    chk("glitch no frame", got_q.size(), 0);
    chk("glitch busy idle", busy, 1'b0);

    // Reset during data bit 4; bit 4 is 1 so the line stays high across reset.
    d = 8'($urandom) | 8'h10;
    rxd = 1'b0;
    wait_clks(64);
    for (int i = 0; i < 4; i++) send_bit(d[i], 64);
    rxd = 1'b1;
    wait_clks(32);
    rst = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    wait_clks(128);
    chk("midrst no frame", got_q.size(), 0);
    chk("midrst rx_data", rx_data, 8'h00);
    chk("midrst frame_err", frame_err, 1'b0);
    chk("midrst parity_err", parity_err, 1'b0);
    chk("midrst busy", busy, 1'b0);
    send_frame(8'h7E, 1'b0, 1'b0, 16, 1'b0, 1'b1, 1'b0);
    send_bit(1'b1, 64);
    check_frames("after reset 7E");

    send_frame(8'h00, 1'b0, 1'b0, 8, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0, 8, 1'b0, 1'b1, 1'b0);
    send_bit(1'b1, 32);
    check_frames("back2back");

    for (int n = 0; n < 24; n++) begin
      d    = 8'($urandom);
      osm  = $urandom_range(4, 16);
      pen  = 1'($urandom);
      podd = 1'($urandom);
      pb   = 1'($urandom);
      sb   = ($urandom_range(0, 3) != 0);
      send_frame(d, pen, podd, osm, pb, sb, 1'($urandom));
      send_bit(1'b1, osm * 4);
      check_frames($sformatf("rand%0d", n));
    end

    chk("rx_valid one cycle", vhigh, vpulse);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
